bellek_denetleyici: RTL and testbench

Request-sequencing controller placed directly upstream of the 16×16 single-port RAM `tek_yollu_bellek`. It accepts read and write requests over a valid/ready interface and buffers them in a small FIFO. It drives the RAM's `cs`/`we`/`oe`/`addr` and its tri-state `data` bus so that writes land on the rising edge and reads use the RAM's falling-edge capture. Read data, and optionally write echoes, are returned over a valid/ready response port.

---
 rtl/bellek_pkg.sv | 15 +
 rtl/istek_fifo.sv | 48 ++++
 rtl/tek_yollu_bellek.sv | 29 ++
 rtl/bellek_denetleyici.sv | 150 +++++++++++++++
 tb/tb_bellek_denetleyici.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bellek_pkg.sv
// Shared constants and FSM state encoding for the bellek_denetleyici RAM controller.
package bellek_pkg;

   localparam int unsigned DefAddrWidth = 4;
   localparam int unsigned DefDataWidth = 16;
   localparam int unsigned DefFifoDepth = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StWrite = 2'b01,
      StRead  = 2'b10,
      StResp  = 2'b11
   } state_e;

endpackage

// File: rtl/istek_fifo.sv
// Synchronous request FIFO; full/empty/count derive from the registered count only.
module istek_fifo #(
   parameter int unsigned WIDTH = 21,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrWidth = $clog2(DEPTH);

   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [PtrWidth-1:0] wptr_q, rptr_q;
   logic [PtrWidth:0]   count_q;
   logic                do_push, do_pop;

   assign full    = (count_q == (PtrWidth + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PtrWidth'(1);
         if (do_pop)  rptr_q <= rptr_q + PtrWidth'(1);
         if (do_push && !do_pop)      count_q <= count_q + (PtrWidth + 1)'(1);
         else if (!do_push && do_pop) count_q <= count_q - (PtrWidth + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/tek_yollu_bellek.sv
// 16x16 single-port RAM: writes on the rising edge, reads latch on the falling edge.
module tek_yollu_bellek #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] addr,
   inout  wire  [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rd_en;

   assign rd_en = cs & oe & ~we;
   assign data  = rd_en ? rd_q : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clk) begin
      if (cs && we) mem_q[addr] <= data;
   end

   always_ff @(negedge clk) begin
      if (rd_en) rd_q <= mem_q[addr];
   end

endmodule

// File: rtl/bellek_denetleyici.sv
// Request sequencer for tek_yollu_bellek: FIFO-buffered requests, one RAM access at a time.
// Optional write echo response: define BELLEK_DENETLEYICI_WRITE_ECHO_EN.
module bellek_denetleyici
   import bellek_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  busy
);

   localparam int unsigned EntryWidth = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

   state_e                state_q, state_d;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EntryWidth-1:0] fifo_wdata, fifo_rdata;
   logic [CountWidth-1:0] fifo_count;
   logic [ADDR_WIDTH-1:0] op_addr_q;
   logic [DATA_WIDTH-1:0] op_wdata_q;
   logic [ADDR_WIDTH-1:0] rsp_addr_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  bus_drive;

   assign fifo_wdata = {req_we, req_addr, req_wdata};
   assign fifo_push  = req_valid & ~fifo_full;
   assign fifo_pop   = (state_q == StIdle) & ~fifo_empty;
   assign req_ready  = ~fifo_full;
   assign busy       = (state_q != StIdle) | (fifo_count != '0);
   assign rsp_addr   = rsp_addr_q;
   assign rsp_data   = rsp_data_q;
   assign mem_data   = bus_drive ? op_wdata_q : {DATA_WIDTH{1'bz}};

   istek_fifo #(
      .WIDTH(EntryWidth),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // The popped entry's we bit is consumed here; the state itself records the op type.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!fifo_empty) state_d = fifo_rdata[EntryWidth-1] ? StWrite : StRead;
`ifdef BELLEK_DENETLEYICI_WRITE_ECHO_EN
         StWrite: state_d = StResp;
`else
         StWrite: state_d = StIdle;
`endif
         StRead:  state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_oe    = 1'b0;
      mem_addr  = '0;
      rsp_valid = 1'b0;
      bus_drive = 1'b0;
      unique case (state_q)
         StWrite: begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = op_addr_q;
            bus_drive = 1'b1;
         end
         StRead: begin
            mem_cs   = 1'b1;
            mem_oe   = 1'b1;
            mem_addr = op_addr_q;
         end
         StResp:  rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         rsp_addr_q <= '0;
         rsp_data_q <= '0;
      end else begin
         if (fifo_pop) begin
            op_addr_q  <= fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
            op_wdata_q <= fifo_rdata[DATA_WIDTH-1:0];
         end
         // RAM output is valid on the bus by the closing edge of READ.
         if (state_q == StRead) begin
            rsp_addr_q <= op_addr_q;
            rsp_data_q <= mem_data;
         end
`ifdef BELLEK_DENETLEYICI_WRITE_ECHO_EN
         if (state_q == StWrite) begin
            rsp_addr_q <= op_addr_q;
            rsp_data_q <= op_wdata_q;
         end
`endif
      end
   end

`ifdef BELLEK_DENETLEYICI_WRITE_ECHO_EN
   logic rsp_we_q;

   always_ff @(posedge clk) begin
      if (reset)                     rsp_we_q <= 1'b0;
      else if (state_q == StWrite)   rsp_we_q <= 1'b1;
      else if (state_q == StRead)    rsp_we_q <= 1'b0;
   end

   assign rsp_we = rsp_we_q;
`else
   assign rsp_we = 1'b0;
`endif

endmodule

// File: tb/tb_bellek_denetleyici.sv
// Directed self-checking bench: controller in front of the tek_yollu_bellek RAM model.
module tb_bellek_denetleyici;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [3:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_we;
   logic [3:0]  rsp_addr;
   logic [15:0] rsp_data;
   logic        mem_cs, mem_we, mem_oe;
   logic [3:0]  mem_addr;
   wire  [15:0] mem_data;
   logic        busy;

   int   compared = 0;
   int   mismatched = 0;
   int   viol = 0;
   logic prev_cs = 1'b0;
   logic saw_full = 1'b0;

   always #5 clk = ~clk;

   bellek_denetleyici u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_addr  (rsp_addr),
      .rsp_data  (rsp_data),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .busy      (busy)
   );

   tek_yollu_bellek u_ram (
      .clk  (clk),
      .cs   (mem_cs),
      .we   (mem_we),
      .oe   (mem_oe),
      .addr (mem_addr),
      .data (mem_data)
   );

   // Bus rule monitor: no write while reading, no two RAM accesses in adjacent cycles.
   always @(negedge clk) begin
      if (reset) begin
         prev_cs = 1'b0;
      end else begin
         if (mem_oe && mem_we) viol++;
         if (mem_cs && prev_cs) viol++;
         prev_cs = mem_cs;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic we, input logic [3:0] a, input logic [15:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 100) begin
         saw_full = 1'b1;
         tick();
         n++;
      end
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL push_accept: req_ready=%b want 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL wait_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic wait_rsp;
      int n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      compared++;
      if (rsp_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL wait_rsp: rsp_valid=%b want 1", rsp_valid);
      end
   endtask

   task automatic collect(input int cnt, input int base);
      int got = 0;
      int n = 0;
      logic [3:0] ea;
      while (got < cnt && n < 400) begin
         if (rsp_valid) begin
            ea = 4'(base + got);
            compared++;
            if (rsp_addr !== ea || rsp_data !== (16'h1000 | 16'(ea)) || rsp_we !== 1'b0) begin
               mismatched++;
               $display("FAIL collect_rsp: addr=%h data=%h we=%b want addr=%h data=%h we=0",
                        rsp_addr, rsp_data, rsp_we, ea, 16'h1000 | 16'(ea));
            end
            got++;
         end
         tick();
         n++;
      end
      compared++;
      if (got != cnt) begin
         mismatched++;
         $display("FAIL collect_count: got=%0d want %0d", got, cnt);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      compared++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_hs: ready=%b rsp_valid=%b busy=%b want 1 0 0",
                  req_ready, rsp_valid, busy);
      end
      compared++;
      if (rsp_we !== 1'b0 || rsp_addr !== 4'h0 || rsp_data !== 16'h0) begin
         mismatched++;
         $display("FAIL reset_rsp: we=%b addr=%h data=%h want 0 0 0", rsp_we, rsp_addr, rsp_data);
      end
      compared++;
      if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0 || mem_addr !== 4'h0) begin
         mismatched++;
         $display("FAIL reset_mem: cs=%b we=%b oe=%b addr=%h want 0 0 0 0",
                  mem_cs, mem_we, mem_oe, mem_addr);
      end
   endtask

   task automatic test_write_read;
      rsp_ready = 1'b1;
      push(1'b1, 4'd3, 16'hBEEF);
      wait_idle();
      rsp_ready = 1'b0;
      push(1'b0, 4'd3, 16'h0);
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL read_lat0: rsp_valid=%b want 0", rsp_valid);
      end
      tick();
      compared++;
      if (rsp_valid !== 1'b0 || mem_oe !== 1'b1 || mem_cs !== 1'b1 || mem_addr !== 4'd3) begin
         mismatched++;
         $display("FAIL read_cycle: rsp_valid=%b oe=%b cs=%b addr=%h want 0 1 1 3",
                  rsp_valid, mem_oe, mem_cs, mem_addr);
      end
      tick();
      compared++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_addr !== 4'd3 || rsp_we !== 1'b0) begin
         mismatched++;
         $display("FAIL read_rsp: valid=%b data=%h addr=%h we=%b want 1 beef 3 0",
                  rsp_valid, rsp_data, rsp_addr, rsp_we);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      rsp_ready = 1'b1;
      saw_full  = 1'b0;
      for (int a = 0; a < 16; a++) push(1'b1, 4'(a), 16'h1000 | 16'(a));
      compared++;
      if (saw_full !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_full: saw_not_ready=%b want 1", saw_full);
      end
      wait_idle();
      fork
         begin
            for (int a = 0; a < 16; a++) push(1'b0, 4'(a), 16'h0);
         end
         collect(16, 0);
      join
      wait_idle();
      rsp_ready = 1'b0;
   endtask

   task automatic test_stall;
      int   n = 0;
      logic rdy;
      rsp_ready = 1'b0;
      push(1'b0, 4'd5, 16'h0);
      wait_rsp();
      for (int c = 0; c < 10; c++) begin
         req_valid = (n < 5);
         req_we    = 1'b0;
         req_addr  = 4'(n);
         rdy       = req_ready;
         tick();
         if (req_valid && rdy) n++;
         compared++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h1005 || rsp_addr !== 4'd5 || mem_cs !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_hold: valid=%b data=%h addr=%h cs=%b want 1 1005 5 0",
                     rsp_valid, rsp_data, rsp_addr, mem_cs);
         end
      end
      req_valid = 1'b0;
      compared++;
      if (n != 4 || req_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL stall_full: accepted=%0d ready=%b want 4 0", n, req_ready);
      end
      rsp_ready = 1'b1;
      tick();
      fork
         collect(5, 0);
         push(1'b0, 4'd4, 16'h0);
      join
      wait_idle();
      rsp_ready = 1'b0;
   endtask

   task automatic test_echo;
      rsp_ready = 1'b0;
      wait_idle();
      push(1'b1, 4'd7, 16'h5A5A);
`ifdef BELLEK_DENETLEYICI_WRITE_ECHO_EN
      wait_rsp();
      compared++;
      if (rsp_we !== 1'b1 || rsp_data !== 16'h5A5A || rsp_addr !== 4'd7) begin
         mismatched++;
         $display("FAIL echo_rsp: we=%b data=%h addr=%h want 1 5a5a 7", rsp_we, rsp_data, rsp_addr);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`else
      begin
         logic seen = 1'b0;
         for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
         end
         compared++;
         if (seen !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL no_echo: saw_rsp_valid=%b busy=%b want 0 0", seen, busy);
         end
      end
`endif
      push(1'b0, 4'd7, 16'h0);
      wait_rsp();
      compared++;
      if (rsp_data !== 16'h5A5A || rsp_we !== 1'b0 || rsp_addr !== 4'd7) begin
         mismatched++;
         $display("FAIL echo_readback: data=%h we=%b addr=%h want 5a5a 0 7",
                  rsp_data, rsp_we, rsp_addr);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_in_resp;
      wait_idle();
      rsp_ready = 1'b0;
      push(1'b0, 4'd9, 16'h0);
      wait_rsp();
      push(1'b1, 4'd9, 16'hDEAD);
      push(1'b0, 4'd1, 16'h0);
      push(1'b0, 4'd2, 16'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_resp: rsp_valid=%b busy=%b ready=%b want 0 0 1",
                  rsp_valid, busy, req_ready);
      end
      push(1'b0, 4'd9, 16'h0);
      wait_rsp();
      compared++;
      if (rsp_data !== 16'h1009 || rsp_addr !== 4'd9) begin
         mismatched++;
         $display("FAIL reset_discard: data=%h addr=%h want 1009 9", rsp_data, rsp_addr);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_bus_rules;
      compared++;
      if (viol != 0) begin
         mismatched++;
         $display("FAIL bus_rules: violations=%0d want 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_stall();
      test_echo();
      test_reset_in_resp();
      test_bus_rules();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
